// File: rtl/free_list_alloc.sv
// rtl/free_list_alloc.sv - bitmap free-list allocator with registered lowest-free tag
//
// Purpose: tracks which of N = 1<<LG_N tags are free and offers the lowest
// free tag from a flop every cycle. Retire/squash returns tags via free_*.
//
// Ports:
//   clk          sole clock, all state on posedge
//   reset_n      synchronous active-low reset
//   alloc_req    consumer takes alloc_id this cycle (only when alloc_avail)
//   alloc_avail  registered: alloc_id is a valid free tag
//   alloc_id     registered: lowest-index free tag (held when empty)
//   free_valid   return free_id to the pool
//   free_id      tag being returned
//   flush        restore the reset-state bitmap, clears double_free
//   free_count   registered number of free tags, 0..N
//   double_free  sticky: a free hit an already-free tag
module free_list_alloc #(
    parameter int LG_N       = 5,
    parameter int N_RESERVED = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            alloc_req,
    output logic            alloc_avail,
    output logic [LG_N-1:0] alloc_id,
    input  logic            free_valid,
    input  logic [LG_N-1:0] free_id,
    input  logic            flush,
    output logic [LG_N:0]   free_count,
    output logic            double_free
);

    localparam int N      = 1 << LG_N;
    localparam int CW     = LG_N + 1;
    localparam int N_LEAF = N / 4;
    localparam int LEVELS = LG_N - 2;

    localparam logic [N-1:0]    RESET_BM    = {N{1'b1}} << N_RESERVED;
    localparam logic            RESET_AVAIL = (N_RESERVED < N);
    localparam logic [LG_N-1:0] RESET_ID    = (N_RESERVED < N) ? LG_N'(N_RESERVED) : '0;
    localparam logic [CW-1:0]   RESET_CNT   = CW'(N - N_RESERVED);

    logic [N-1:0]    bitmap_q, bitmap_d;
    logic            avail_q, avail_d;
    logic [LG_N-1:0] id_q, id_d;
    logic [CW-1:0]   count_q, count_d;
    logic            dfree_q, dfree_d;

    logic            fire;
    logic            dup;

    // Search tree: level 0 holds 4-bit leaves, each higher level merges
    // pairs of nodes, preferring the lower-indexed half.
    logic            t_v   [LEVELS+1][N_LEAF];
    logic [LG_N-1:0] t_idx [LEVELS+1][N_LEAF];

    assign fire = alloc_req & avail_q;
    // A same-cycle grant of free_id means the bit is being cleared first,
    // so freeing it is a legitimate return rather than a double free.
    assign dup  = bitmap_q[free_id] & ~(fire && (id_q == free_id));

    always_comb begin
        bitmap_d = bitmap_q;
        if (fire) begin
            bitmap_d[id_q] = 1'b0;
        end
        if (free_valid) begin
            bitmap_d[free_id] = 1'b1;
        end
    end

    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            for (int j = 0; j < N_LEAF; j++) begin
                t_v[l][j]   = 1'b0;
                t_idx[l][j] = '0;
            end
        end
        for (int j = 0; j < N_LEAF; j++) begin
            t_v[0][j] = |bitmap_d[4*j +: 4];
            if (bitmap_d[4*j]) begin
                t_idx[0][j] = LG_N'(4*j);
            end else if (bitmap_d[4*j+1]) begin
                t_idx[0][j] = LG_N'(4*j + 1);
            end else if (bitmap_d[4*j+2]) begin
                t_idx[0][j] = LG_N'(4*j + 2);
            end else begin
                t_idx[0][j] = LG_N'(4*j + 3);
            end
        end
        for (int l = 1; l <= LEVELS; l++) begin
            for (int j = 0; j < (N_LEAF >> l); j++) begin
                t_v[l][j]   = t_v[l-1][2*j] | t_v[l-1][2*j+1];
                t_idx[l][j] = t_v[l-1][2*j] ? t_idx[l-1][2*j] : t_idx[l-1][2*j+1];
            end
        end
    end

    always_comb begin
        avail_d = t_v[LEVELS][0];
        // When nothing is free the old id is kept; consumers ignore it.
        id_d    = t_v[LEVELS][0] ? t_idx[LEVELS][0] : id_q;
        count_d = count_q - CW'(fire) + CW'(free_valid & ~dup);
        dfree_d = dfree_q | (free_valid & dup);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            bitmap_q <= RESET_BM;
            avail_q  <= RESET_AVAIL;
            id_q     <= RESET_ID;
            count_q  <= RESET_CNT;
            dfree_q  <= 1'b0;
        end else begin
            bitmap_q <= bitmap_d;
            avail_q  <= avail_d;
            id_q     <= id_d;
            count_q  <= count_d;
            dfree_q  <= dfree_d;
        end
    end

    assign alloc_avail = avail_q;
    assign alloc_id    = id_q;
    assign free_count  = count_q;
    assign double_free = dfree_q;

endmodule
